// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Build option: DIV_SIGNED_EN adds the FIXUP state for two's-complement operands.
package div_pkg;

  localparam int DIV_DEFAULT_WIDTH = 16;
  localparam int DIV_CNT_W         = $clog2(DIV_DEFAULT_WIDTH);

  // Width of the bit counter for a given operand width (never below 1 bit).
  function automatic int div_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef DIV_SIGNED_EN
    FIXUP = 2'd2,
`endif
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake, operands and results of the sequential divider.
// master: requester side, slave: divider side.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// try subtracting the divisor, keep the difference if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_unused_trial_msb;

  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  // The partial remainder stays below the divisor, so a successful trial
  // always fits back into WIDTH bits; its top bit carries no information.
  assign w_unused_trial_msb = w_trial[WIDTH];

  // Explicit compare gives the sign of the trial without a borrow bit.
  assign o_qbit = (w_shifted >= {1'b0, i_divisor});
  assign o_rem  = o_qbit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake, results held until the
// next accepted start.
// Build option: DIV_SIGNED_EN -> two's-complement operands with a one-cycle
// FIXUP state for sign correction and the final range check.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_t          r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0]    r_rem, w_rem_next;          // partial remainder, final remainder
  logic [WIDTH-1:0]    r_quo, w_quo_next;          // quotient shift register / result
  logic [WIDTH-1:0]    r_dvd_lo, w_dvd_lo_next;    // dividend bits still to be consumed
  logic [WIDTH-1:0]    r_divisor, w_divisor_next;
  logic                r_dbz, w_dbz_next;
  logic                r_ovf, w_ovf_next;

  logic [2*WIDTH-1:0]  w_dvd_mag;
  logic [WIDTH-1:0]    w_dsr_mag;
  logic [WIDTH-1:0]    w_step_rem;
  logic                w_step_qbit;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] Q_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic                r_neg_q, w_neg_q_next;      // operand signs differ
  logic                r_neg_r, w_neg_r_next;      // dividend negative
  logic [WIDTH-1:0]    r_dvd_raw_lo, w_dvd_raw_lo_next;

  assign w_dvd_mag = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_dsr_mag = bus.divisor[WIDTH-1]    ? -bus.divisor  : bus.divisor;
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dsr_mag = bus.divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd_lo[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvd_lo  <= '0;
      r_divisor <= '0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_dvd_raw_lo <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rem     <= w_rem_next;
      r_quo     <= w_quo_next;
      r_dvd_lo  <= w_dvd_lo_next;
      r_divisor <= w_divisor_next;
      r_dbz     <= w_dbz_next;
      r_ovf     <= w_ovf_next;
`ifdef DIV_SIGNED_EN
      r_neg_q      <= w_neg_q_next;
      r_neg_r      <= w_neg_r_next;
      r_dvd_raw_lo <= w_dvd_raw_lo_next;
`endif
    end
  end

  // Next-state and datapath update: accept, iterate, sign-fix, report.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rem_next     = r_rem;
    w_quo_next     = r_quo;
    w_dvd_lo_next  = r_dvd_lo;
    w_divisor_next = r_divisor;
    w_dbz_next     = r_dbz;
    w_ovf_next     = r_ovf;
`ifdef DIV_SIGNED_EN
    w_neg_q_next      = r_neg_q;
    w_neg_r_next      = r_neg_r;
    w_dvd_raw_lo_next = r_dvd_raw_lo;
`endif

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_dbz_next     = 1'b0;
          w_ovf_next     = 1'b0;
          w_quo_next     = '0;
          w_divisor_next = w_dsr_mag;
          w_dvd_lo_next  = w_dvd_mag[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
          w_neg_q_next      = bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1];
          w_neg_r_next      = bus.dividend[2*WIDTH-1];
          w_dvd_raw_lo_next = bus.dividend[WIDTH-1:0];
`endif
          if (bus.divisor == '0) begin
            w_dbz_next   = 1'b1;
            w_quo_next   = '1;
            w_rem_next   = bus.dividend[WIDTH-1:0];
            w_state_next = DONE;
          end else if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dsr_mag) begin
            // Quotient would need more than WIDTH bits.
            w_ovf_next   = 1'b1;
            w_quo_next   = '1;
            w_rem_next   = bus.dividend[WIDTH-1:0];
            w_state_next = DONE;
          end else begin
            w_rem_next   = w_dvd_mag[2*WIDTH-1:WIDTH];
            w_cnt_next   = CNT_W'(WIDTH-1);
            w_state_next = CALC;
          end
        end
      end

      CALC: begin
        w_rem_next    = w_step_rem;
        w_quo_next    = {r_quo[WIDTH-2:0], w_step_qbit};
        w_dvd_lo_next = {r_dvd_lo[WIDTH-2:0], 1'b0};
        if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
          w_state_next = FIXUP;
`else
          w_state_next = DONE;
`endif
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

`ifdef DIV_SIGNED_EN
      FIXUP: begin
        // Negative results may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
        if (r_quo > (r_neg_q ? Q_NEG_MAX : Q_POS_MAX)) begin
          w_ovf_next = 1'b1;
          w_quo_next = '1;
          w_rem_next = r_dvd_raw_lo;
        end else begin
          w_quo_next = r_neg_q ? -r_quo : r_quo;
          w_rem_next = r_neg_r ? -r_rem : r_rem;
        end
        w_state_next = DONE;
      end
`endif

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic model.
// Honours DIV_SIGNED_EN in the same way as the design.
module tb_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, then the error/range rules.
  function automatic exp_t model(input logic [31:0] dvd, input logic [W-1:0] dsr);
    exp_t   e;
    longint a, b, q, r, mq;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.q   = '0;
    e.r   = '0;
`ifdef DIV_SIGNED_EN
    a     = longint'($signed(dvd));
    b     = longint'($signed(dsr));
    e.lat = W + 2;
`else
    a     = longint'(dvd);
    b     = longint'(dsr);
    e.lat = W + 1;
`endif
    if (b == 0) begin
      e.dbz = 1'b1;
      e.q   = '1;
      e.r   = dvd[W-1:0];
      e.lat = 1;
      return e;
    end
    q  = a / b;
    r  = a % b;
    mq = (q < 0) ? -q : q;
    if (mq >= (longint'(1) << W)) begin
      e.ovf = 1'b1;
      e.q   = '1;
      e.r   = dvd[W-1:0];
      e.lat = 1;
`ifdef DIV_SIGNED_EN
    end else if (q > 32767 || q < -32768) begin
      e.ovf = 1'b1;
      e.q   = '1;
      e.r   = dvd[W-1:0];
`endif
    end else begin
      e.q = q[W-1:0];
      e.r = r[W-1:0];
    end
    return e;
  endfunction

  // One transaction: start pulse, bounded wait for done, result and
  // handshake checks, then a start in the DONE cycle that must be ignored.
  task automatic run_op(input logic [31:0] dvd, input logic [W-1:0] dsr, input bit mid_start);
    exp_t e;
    int   edges;
    bit   busy_ok;
    e = model(dvd, dsr);
    @(negedge clk);
    bus.dividend = dvd;
    bus.divisor  = dsr;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    edges        = 1;
    busy_ok      = bus.busy;
    bus.dividend = $urandom;
    bus.divisor  = W'($urandom);
    while (!bus.done && edges < 40) begin
      bus.start = (mid_start && edges == 3);
      @(posedge clk);
      #1;
      edges++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(bus.done), 32'd1);
    check("latency", edges, e.lat);
    check("busy_during_op", 32'(busy_ok), 32'd1);
    check("quotient", 32'(bus.quotient), 32'(e.q));
    check("remainder", 32'(bus.remainder), 32'(e.r));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
    check("overflow", 32'(bus.overflow), 32'(e.ovf));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("quotient_held", 32'(bus.quotient), 32'(e.q));
    check("remainder_held", 32'(bus.remainder), 32'(e.r));
    $display("[TB] op %08h / %04h -> q=%04h r=%04h dbz=%0d ovf=%0d lat=%0d",
             dvd, dsr, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, edges);
  endtask

  initial begin
    logic [31:0] t0, t1;
    logic [W-1:0] dsr;
    logic [31:0] dvd;
    bit saw_done;

    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);

    run_op(32'd100000, 16'd7, 1'b1);
`ifndef DIV_SIGNED_EN
    check("tp_q_100000_7", 32'(bus.quotient), 32'd14285);
    check("tp_r_100000_7", 32'(bus.remainder), 32'd5);
`endif
    run_op(32'hFFFE0001, 16'hFFFF, 1'b0);
    run_op(32'd1234, 16'd0, 1'b0);
    check("tp_dbz_q", 32'(bus.quotient), 32'h0000FFFF);
    check("tp_dbz_r", 32'(bus.remainder), 32'h000004D2);
    run_op(32'h00010000, 16'd1, 1'b0);
    check("tp_ovf_flag", 32'(bus.overflow), 32'd1);
    run_op(32'd100, 16'd10, 1'b0);
    check("tp_q_100_10", 32'(bus.quotient), 32'd10);
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFFFF9C, 16'd7, 1'b0);
    check("tp_signed_q", 32'(bus.quotient), 32'h0000FFF2);
    check("tp_signed_r", 32'(bus.remainder), 32'h0000FFFE);
`endif

    // Reset in the middle of an operation: no done, reset values restored.
    saw_done = 1'b0;
    @(negedge clk);
    bus.dividend = 32'd100000;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 2; e <= 8; e++) begin
      @(negedge clk);
      bus.start = (e == 4);
      if (e == 4) begin
        bus.dividend = 32'd50;
        bus.divisor  = 16'd5;
      end
      reset = (e == 8);
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    $display("[TB] reset mid-operation at edge 8");
    run_op(32'd50, 16'd5, 1'b0);

    for (int i = 0; i < 150; i++) begin
      t0  = $urandom;
      t1  = $urandom;
      dsr = t1[W-1:0];
      case ($urandom_range(0, 3))
        0: dvd = t0;
        1: dvd = {((dsr == 0) ? t0[31:16] : (t0[31:16] % dsr)), t0[15:0]};
        2: begin
          dsr = W'($urandom_range(0, 3));
          dvd = t0;
        end
        default: dvd = t0[15:0] * t1[31:16];
      endcase
      if (i % 40 == 3) dsr = '0;
      run_op(dvd, dsr, (i % 5 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative restoring divider and the inverse companion to the team's 16x16 combinational multiplier. It divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient bit per clock. Start/done handshake; results and status flags are held registered until the next accepted start. Intended to check multiplier products (product / B == A, remainder 0) and for general datapath use.

Parameters:
WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy==0
dividend  input  2*WIDTH  sampled on the accepting edge
divisor  input  WIDTH  sampled on the accepting edge
busy  output  1  high from the accepting edge until done drops
done  output  1  one-cycle pulse; result valid
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  sampled divisor was 0
overflow  output  1  quotient not representable in WIDTH bits

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, div_by_zero and overflow are 0; quotient and remainder are 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, FIXUP (present only with DIV_SIGNED_EN), DONE.
- IDLE: start=1 -> latch operands, clear both flags, busy=1.
  - divisor==0: div_by_zero=1, quotient=all ones, remainder=dividend[WIDTH-1:0], go to DONE.
  - else if dividend[2W-1:W] >= divisor: overflow=1, same quotient/remainder fill, go to DONE.
  - else: partial remainder=dividend[2W-1:W], count=WIDTH-1, go to CALC.
- CALC, each edge: trial = {partial_rem, next dividend bit} - divisor, computed WIDTH+1 bits wide.
  - Non-negative: keep trial, shift quotient bit 1.
  - Negative: restore, shift 0.
  - At count==0 go to DONE (or FIXUP when signed); otherwise decrement count.
- DONE: done=1 for exactly one cycle, then IDLE, busy=0. Outputs hold until the next accepted start.
- Latency (unsigned): done is high in the cycle after WIDTH+1 edges counted from the accepting edge. Error paths: done after 1 edge.
- start while busy: ignored, not queued. start in the DONE cycle is also ignored.
- start and reset on the same edge: reset wins.
- Operands may change freely after the accepting edge.

Optional Feature:
Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement; the datapath divides magnitudes.
  - FIXUP state, one cycle, placed after CALC: negate quotient if operand signs differ; remainder takes the dividend's sign.
  - Overflow if magnitude quotient > 2^(W-1)-1, or > 2^(W-1) when the result is negative. The pre-check uses magnitudes; FIXUP performs the final range check.
  - Latency is WIDTH+2 edges.
- Undefined: unsigned only; no FIXUP state.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, FIXUP, DONE); localparam DIV_DEFAULT_WIDTH=16; count width constant $clog2(WIDTH).
- Sub-module div_step: combinational single restoring step. Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder, quotient bit.

Test Plan:
- WIDTH=16; dividend=100000, divisor=7; one-cycle start -> done at edge 17: quotient=14285, remainder=5, both flags 0; busy high for the whole run.
- dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0.
- dividend=1234, divisor=0 -> done after 1 edge: div_by_zero=1, quotient=16'hFFFF, remainder=16'h04D2.
- dividend=32'h00010000, divisor=1 -> overflow=1, done after 1 edge. Next run, 100/10: flags clear, quotient=10, remainder=0.
- Start 100000/7; pulse start with 50/5 at edge 4; assert reset at edge 8; after reset start 50/5 -> no done from the first run, reset values restored, second op gives quotient=10, remainder=0.
- DIV_SIGNED_EN: dividend=32'hFFFFFF9C (-100), divisor=7 -> done at edge 18: quotient=16'hFFF2 (-14), remainder=16'hFFFE (-2).
